fpcvt_pipe: RTL and testbench

- Pipelined, parametrised two's-complement to sign/exponent/significand floating-point converter with valid/ready handshaking.
- Generalises the fixed 12-bit to 1+3+4 combinational converter: widths are parameters, rounding is selectable per sample, saturation is flagged, and saturation events are counted.
- Sits between the linear sample source and downstream compressed-sample consumers.
- Encoded value = (-1)^S * F * 2^E.

---
 rtl/fpcvt_pipe.sv | 209 ++++++++++++++++++++
 tb/tb_fpcvt_pipe.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpcvt_pipe.sv
// fpcvt_pipe: three-stage two's-complement to sign/exponent/significand
// converter. Encoded value = (-1)^S * F * 2^E.
//
// Handshake: a sample moves in when in_valid & in_ready, and a result moves
// out when out_valid & out_ready. Every stage advances together on
// en = !out_valid | out_ready, and in_ready is en. When en is low, every
// stage holds and the outputs stay frozen.
module fpcvt_pipe #(
   parameter int IN_W     = 12,
   parameter int EXP_W    = 3,
   parameter int MAN_W    = 4,
   parameter int SATCNT_W = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [IN_W-1:0]     in_data,
   input  logic                in_round,
   output logic                out_valid,
   input  logic                out_ready,
   output logic                out_s,
   output logic [EXP_W-1:0]    out_e,
   output logic [MAN_W-1:0]    out_f,
   output logic                out_sat,
   output logic [SATCNT_W-1:0] sat_count,
   input  logic                sat_clr
);

   localparam int E_MAX = (2 ** EXP_W) - 1;
   // The internal exponent has to hold both the largest exponent after a
   // rounding carry (IN_W-MAN_W+1) and anything above E_MAX. It also has to
   // hold the bit index p.
   localparam int CW_A = $clog2(IN_W + 2) + 1;
   localparam int CW   = (CW_A > EXP_W + 1) ? CW_A : EXP_W + 1;

   logic en;

   // stage 1: sign, magnitude, rounding mode
   logic            v1_q, v1_d, s1_q, s1_d, rnd1_q, rnd1_d;
   logic [IN_W-1:0] mag1_q, mag1_d;
   // stage 2: normalised exponent, significand, round bit
   logic             v2_q, v2_d, s2_q, s2_d, r2_q, r2_d, rnd2_q, rnd2_d;
   logic [CW-1:0]    e2_q, e2_d;
   logic [MAN_W-1:0] f2_q, f2_d;
   // stage 3: output registers
   logic                out_valid_q, out_valid_d, out_s_q, out_s_d;
   logic                out_sat_q, out_sat_d;
   logic [EXP_W-1:0]    out_e_q, out_e_d;
   logic [MAN_W-1:0]    out_f_q, out_f_d;
   logic [SATCNT_W-1:0] sat_count_q, sat_count_d;

   assign en        = ~out_valid_q | out_ready;
   assign in_ready  = en;
   assign out_valid = out_valid_q;
   assign out_s     = out_s_q;
   assign out_e     = out_e_q;
   assign out_f     = out_f_q;
   assign out_sat   = out_sat_q;
   assign sat_count = sat_count_q;

   // Stage 1: take the sign and form the unsigned magnitude. The most
   // negative input maps to 2^(IN_W-1), which still fits in IN_W bits.
   always_comb begin
      v1_d   = v1_q;
      s1_d   = s1_q;
      mag1_d = mag1_q;
      rnd1_d = rnd1_q;
      if (en) begin
         v1_d   = in_valid;
         s1_d   = in_data[IN_W-1];
         mag1_d = in_data[IN_W-1] ? (~in_data + IN_W'(1)) : in_data;
         rnd1_d = in_round;
      end
   end

   // Stage 2: find the leading one and extract the significand and round bit
   logic [CW-1:0]    p;
   logic             found;
   logic [IN_W-1:0]  sh;
   logic             s_c, r_c;
   logic [CW-1:0]    e_c;
   logic [MAN_W-1:0] f_c;
   always_comb begin
      p     = '0;
      found = 1'b0;
      for (int i = 0; i < IN_W; i++) begin
         if (mag1_q[i]) begin
            p     = CW'(i);
            found = 1'b1;
         end
      end
      // When p >= MAN_W, sh[0] is the first discarded bit and sh[MAN_W:1]
      // is the kept significand. When p < MAN_W this value is not used.
      sh  = mag1_q >> (p - CW'(MAN_W));
      s_c = s1_q;
      e_c = '0;
      f_c = '0;
      r_c = 1'b0;
      if (!found) begin
         s_c = 1'b0;
      end else if (p < CW'(MAN_W)) begin
         f_c = mag1_q[MAN_W-1:0];
      end else begin
         e_c = p - CW'(MAN_W - 1);
         f_c = sh[MAN_W:1];
         r_c = sh[0];
      end
      v2_d   = v2_q;
      s2_d   = s2_q;
      e2_d   = e2_q;
      f2_d   = f2_q;
      r2_d   = r2_q;
      rnd2_d = rnd2_q;
      if (en) begin
         v2_d   = v1_q;
         s2_d   = s_c;
         e2_d   = e_c;
         f2_d   = f_c;
         r2_d   = r_c;
         rnd2_d = rnd1_q;
      end
   end

   // Stage 3: round, renormalise on a carry out, then clamp to E_MAX
   logic [MAN_W:0]   fr;
   logic [CW-1:0]    er;
   logic [MAN_W-1:0] fo;
   logic [EXP_W-1:0] eo;
   logic             so;
   always_comb begin
      fr = {1'b0, f2_q} + {{MAN_W{1'b0}}, (rnd2_q & r2_q)};
      er = e2_q;
      fo = fr[MAN_W-1:0];
      so = 1'b0;
      if (fr[MAN_W]) begin
         fo = MAN_W'(1) << (MAN_W - 1);
         er = e2_q + CW'(1);
      end
      eo = er[EXP_W-1:0];
      if (er > CW'(E_MAX)) begin
         eo = '1;
         fo = '1;
         so = 1'b1;
      end
      out_valid_d = out_valid_q;
      out_s_d     = out_s_q;
      out_e_d     = out_e_q;
      out_f_d     = out_f_q;
      out_sat_d   = out_sat_q;
      if (en) begin
         out_valid_d = v2_q;
         out_s_d     = s2_q;
         out_e_d     = eo;
         out_f_d     = fo;
         out_sat_d   = so;
      end
   end

   // Saturation event counter: clear wins; holds at all-ones
   always_comb begin
      sat_count_d = sat_count_q;
      if (sat_clr) begin
         sat_count_d = '0;
      end else if (out_valid_q & out_ready & out_sat_q & ~(&sat_count_q)) begin
         sat_count_d = sat_count_q + SATCNT_W'(1);
      end
   end

   // State registers with synchronous reset; reset drops any in-flight samples
   always_ff @(posedge clk) begin
      if (rst) begin
         v1_q        <= 1'b0;
         s1_q        <= 1'b0;
         mag1_q      <= '0;
         rnd1_q      <= 1'b0;
         v2_q        <= 1'b0;
         s2_q        <= 1'b0;
         e2_q        <= '0;
         f2_q        <= '0;
         r2_q        <= 1'b0;
         rnd2_q      <= 1'b0;
         out_valid_q <= 1'b0;
         out_s_q     <= 1'b0;
         out_e_q     <= '0;
         out_f_q     <= '0;
         out_sat_q   <= 1'b0;
         sat_count_q <= '0;
      end else begin
         v1_q        <= v1_d;
         s1_q        <= s1_d;
         mag1_q      <= mag1_d;
         rnd1_q      <= rnd1_d;
         v2_q        <= v2_d;
         s2_q        <= s2_d;
         e2_q        <= e2_d;
         f2_q        <= f2_d;
         r2_q        <= r2_d;
         rnd2_q      <= rnd2_d;
         out_valid_q <= out_valid_d;
         out_s_q     <= out_s_d;
         out_e_q     <= out_e_d;
         out_f_q     <= out_f_d;
         out_sat_q   <= out_sat_d;
         sat_count_q <= sat_count_d;
      end
   end

endmodule

// File: tb/tb_fpcvt_pipe.sv
// Bench for fpcvt_pipe with default parameters: a table of directed vectors
// plus hand-written sequences for sat_count, backpressure and reset.
module tb_fpcvt_pipe;

   typedef struct {
      logic [11:0] data;
      logic        rnd;
      logic [8:0]  exp;   // {s, e[2:0], f[3:0], sat}
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [11:0] in_data = '0;
   logic        in_round = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic        out_s;
   logic [2:0]  out_e;
   logic [3:0]  out_f;
   logic        out_sat;
   logic [7:0]  sat_count;
   logic        sat_clr = 1'b0;

   fpcvt_pipe #(.IN_W(12), .EXP_W(3), .MAN_W(4), .SATCNT_W(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_round(in_round), .out_valid(out_valid),
      .out_ready(out_ready), .out_s(out_s), .out_e(out_e), .out_f(out_f),
      .out_sat(out_sat), .sat_count(sat_count), .sat_clr(sat_clr)
   );

   // clock
   always #5 clk = ~clk;

   int          cyc = 0;
   int          n_cmp = 0;
   int          n_err = 0;
   logic [8:0]  exp_q[$];
   int          acc_q[$];
   logic [8:0]  cur_exp = '0;
   bit          chk_on = 0;
   bit          chk_lat = 1;
   bit          bp_en = 0;
   int          bp_idx = 0;
   logic [7:0]  bp_pat = 8'b11101001;   // bit i is out_ready in pattern cycle i
   bit          prev_stall = 0;
   logic [8:0]  prev_out = '0;
   vec_t        tbl[14];

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [8:0] mk(input logic s, input int e, input int f, input logic sat);
      return {s, 3'(e), 4'(f), sat};
   endfunction

   // out_ready driver: held high or following the backpressure pattern
   always @(posedge clk) begin
      #1;
      if (bp_en) begin
         out_ready = bp_pat[bp_idx];
         bp_idx = (bp_idx + 1) % 8;
      end else begin
         out_ready = 1'b1;
      end
   end

   // scoreboard / monitor, sampled on the falling edge
   always @(negedge clk) begin
      logic [8:0] got, e;
      int a;
      got = {out_s, out_e, out_f, out_sat};
      if (rst) begin
         prev_stall = 0;
      end else if (chk_on) begin
         n_cmp++;
         if (in_ready !== (!out_valid || out_ready)) begin
            n_err++;
            $display("FAIL in_ready: got %b, required %b", in_ready, (!out_valid || out_ready));
         end
         if (prev_stall) begin
            n_cmp++;
            if (out_valid !== 1'b1 || got !== prev_out) begin
               n_err++;
               $display("FAIL stall_hold: got valid=%b out=%h, required valid=1 out=%h", out_valid, got, prev_out);
            end
         end
         if (out_valid && out_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL unexpected_output: got %h, required no output", got);
            end else begin
               e = exp_q.pop_front();
               a = acc_q.pop_front();
               if (got !== e) begin
                  n_err++;
                  $display("FAIL result: got s/e/f/sat=%h, required %h (cycle %0d)", got, e, cyc);
               end
               if (chk_lat) begin
                  n_cmp++;
                  if (cyc - a != 3) begin
                     n_err++;
                     $display("FAIL latency: got %0d, required 3", cyc - a);
                  end
               end
            end
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(cur_exp);
            acc_q.push_back(cyc);
         end
         prev_stall = out_valid && !out_ready;
         prev_out   = got;
      end
   end

   task automatic send(input vec_t v);
      bit acc;
      int n;
      in_valid = 1'b1;
      in_data  = v.data;
      in_round = v.rnd;
      cur_exp  = v.exp;
      acc = 0;
      n = 0;
      while (!acc && n < 100) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
         n++;
      end
      in_valid = 1'b0;
      if (!acc) begin
         n_cmp++;
         n_err++;
         $display("FAIL send_timeout: got in_ready=0 for %0d cycles, required acceptance", n);
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(posedge clk);
         n++;
      end
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL drain_timeout: got %0d results outstanding, required 0", exp_q.size());
      end
      @(posedge clk);
      #1;
   endtask

   task automatic check_sc(input logic [7:0] req, input string name);
      @(negedge clk);
      n_cmp++;
      if (sat_count !== req) begin
         n_err++;
         $display("FAIL %s: got sat_count=%0d, required %0d", name, sat_count, req);
      end
   endtask

   initial begin
      vec_t v;
      int n;
      tbl[0]  = '{12'd422,    1'b1, mk(0, 5, 13, 0)};
      tbl[1]  = '{12'd0,      1'b1, mk(0, 0, 0, 0)};
      tbl[2]  = '{12'(-5),    1'b1, mk(1, 0, 5, 0)};
      tbl[3]  = '{12'd46,     1'b1, mk(0, 2, 12, 0)};
      tbl[4]  = '{12'd46,     1'b0, mk(0, 2, 11, 0)};
      tbl[5]  = '{12'd125,    1'b1, mk(0, 4, 8, 0)};
      tbl[6]  = '{12'd2047,   1'b1, mk(0, 7, 15, 1)};
      tbl[7]  = '{12'(-2048), 1'b1, mk(1, 7, 15, 1)};
      tbl[8]  = '{12'(-422),  1'b0, mk(1, 5, 13, 0)};
      tbl[9]  = '{12'd2047,   1'b0, mk(0, 7, 15, 0)};
      tbl[10] = '{12'd15,     1'b1, mk(0, 0, 15, 0)};
      tbl[11] = '{12'd16,     1'b1, mk(0, 1, 8, 0)};
      tbl[12] = '{12'd31,     1'b1, mk(0, 2, 8, 0)};
      tbl[13] = '{12'd1983,   1'b1, mk(0, 7, 15, 0)};

      // reset
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b0 || sat_count !== 8'd0) begin
         n_err++;
         $display("FAIL reset_state: got valid=%b sat_count=%0d, required 0 0", out_valid, sat_count);
      end
      n_cmp++;
      if ({out_s, out_e, out_f, out_sat} !== 9'd0) begin
         n_err++;
         $display("FAIL reset_outputs: got %h, required 000", {out_s, out_e, out_f, out_sat});
      end
      n_cmp++;
      if (in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL reset_in_ready: got %b, required 1", in_ready);
      end
      chk_on = 1;
      @(posedge clk);
      #1;

      // table vectors back-to-back at full rate
      for (int i = 0; i < 14; i++) send(tbl[i]);
      drain();
      check_sc(8'd2, "sat_count_two");

      // sat_clr wins over a simultaneous saturated handshake
      send(tbl[6]);
      n = 0;
      while (!out_valid && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      sat_clr = 1'b1;
      @(posedge clk);
      #1 sat_clr = 1'b0;
      check_sc(8'd0, "sat_clr_priority");
      drain();

      // counter holds at all-ones
      for (int i = 0; i < 258; i++) send(tbl[6]);
      drain();
      check_sc(8'hFF, "sat_count_hold");
      @(posedge clk);
      #1 sat_clr = 1'b1;
      @(posedge clk);
      #1 sat_clr = 1'b0;
      check_sc(8'd0, "sat_clr_plain");

      // backpressure
      chk_lat = 0;
      bp_idx = 0;
      bp_en = 1;
      for (int i = 0; i < 8; i++) send(tbl[i]);
      drain();
      bp_en = 0;
      @(posedge clk);
      #1 chk_lat = 1;
      check_sc(8'd2, "sat_count_bp");

      // reset with samples in flight
      @(posedge clk);
      #1;
      send(tbl[6]);
      send(tbl[7]);
      send(tbl[2]);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      exp_q.delete();
      acc_q.delete();
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b0 || sat_count !== 8'd0) begin
         n_err++;
         $display("FAIL mid_reset: got valid=%b sat_count=%0d, required 0 0", out_valid, sat_count);
      end
      repeat (6) @(posedge clk);
      #1;
      v = tbl[5];
      send(v);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule
